// File: rtl/juego_led_main.sv
// Two-player LED reaction game: synchronized buttons, LFSR random delay, round FSM, score and round display.
// Define SEG_ACTIVE_LOW_EN to drive a common-anode (active-low) 7-segment digit.
module juego_led_main #(
  parameter int WAIT_MIN    = 8,
  parameter int WAIT_MASK   = 7,
  parameter int GO_TIMEOUT  = 32,
  parameter int RESULT_HOLD = 4,
  parameter int WIN_SCORE   = 3
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       BotonA,
  input  logic       BotonB,
  output logic       LedRED,
  output logic       LedVerde,
  output logic       LedFin,
  output logic [6:0] displaytotal,
  output logic       Switch0,
  output logic       Switch1,
  output logic       Switch2,
  output logic       Switch3
);

  localparam int CW = 8;
  localparam logic [1:0] WIN = 2'(WIN_SCORE);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_GO, ST_RESULT, ST_FIN} state_t;

  state_t        state, state_n;
  logic [2:0]    sync1, sync2, sync3, press;
  logic          start_p, a_p, b_p;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    score_a, score_a_n, score_b, score_b_n;
  logic [3:0]    rounds, rounds_n;
  logic          led_red, red_n, led_verde, verde_n, led_fin, fin_n;
  logic [6:0]    seg, seg_n;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] s);
    return (s == WIN) ? s : s + 2'd1;
  endfunction

  function automatic logic [3:0] round_inc(input logic [3:0] r);
    return (r == 4'd9) ? 4'd0 : r + 4'd1;
  endfunction

  // 2-flop synchronizer, then a registered rising-edge pulse per input
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clock) begin
    if (!Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      press <= '0;
      lfsr  <= 16'hACE1;
    end else begin
      sync1 <= {BotonB, BotonA, Start};
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync2 & ~sync3;
      lfsr  <= {lfsr[14:0], lfsr_fb};
    end
  end

  assign start_p = press[0];
  assign a_p     = press[1];
  assign b_p     = press[2];

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      score_a   <= '0;
      score_b   <= '0;
      rounds    <= '0;
      led_red   <= 1'b0;
      led_verde <= 1'b0;
      led_fin   <= 1'b0;
      seg       <= seg7(4'd0);
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      score_a   <= score_a_n;
      score_b   <= score_b_n;
      rounds    <= rounds_n;
      led_red   <= red_n;
      led_verde <= verde_n;
      led_fin   <= fin_n;
      seg       <= seg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    score_a_n = score_a;
    score_b_n = score_b;
    rounds_n  = rounds;
    red_n     = led_red;
    verde_n   = led_verde;
    fin_n     = led_fin;
    case (state)
      ST_IDLE: begin
        red_n   = 1'b0;
        verde_n = 1'b0;
        if (start_p) begin
          cnt_n   = CW'(WAIT_MIN) + CW'(lfsr & 16'(WAIT_MASK));
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Button fouls win over the delay expiring in the same cycle
        if (a_p && b_p) begin
          red_n   = 1'b1;
          state_n = ST_RESULT;
        end else if (a_p) begin
          score_b_n = sat_inc(score_b);
          red_n     = 1'b1;
          state_n   = ST_RESULT;
        end else if (b_p) begin
          score_a_n = sat_inc(score_a);
          red_n     = 1'b1;
          state_n   = ST_RESULT;
        end else if (cnt == '0) begin
          verde_n = 1'b1;
          state_n = ST_GO;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_GO: begin
        if (a_p && b_p) begin
          red_n   = 1'b1;
          state_n = ST_RESULT;
        end else if (a_p) begin
          score_a_n = sat_inc(score_a);
          state_n   = ST_RESULT;
        end else if (b_p) begin
          score_b_n = sat_inc(score_b);
          state_n   = ST_RESULT;
        end else if (cnt == CW'(GO_TIMEOUT - 1)) begin
          red_n   = 1'b1;
          state_n = ST_RESULT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_RESULT: begin
        if (cnt == CW'(RESULT_HOLD - 1)) begin
          red_n   = 1'b0;
          verde_n = 1'b0;
          cnt_n   = '0;
          if (score_a == WIN || score_b == WIN) begin
            fin_n   = 1'b1;
            state_n = ST_FIN;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_FIN: begin
        if (start_p) begin
          score_a_n = '0;
          score_b_n = '0;
          rounds_n  = '0;
          fin_n     = 1'b0;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Round count and hold timer start on every entry into RESULT
    if (state != ST_RESULT && state_n == ST_RESULT) begin
      rounds_n = round_inc(rounds);
      cnt_n    = '0;
    end
    seg_n = seg7(rounds_n);
  end

  assign LedRED       = led_red;
  assign LedVerde     = led_verde;
  assign LedFin       = led_fin;
  assign displaytotal = seg;
  assign Switch0      = score_a[0];
  assign Switch1      = score_a[1];
  assign Switch2      = score_b[0];
  assign Switch3      = score_b[1];

endmodule

// File: tb/tb_juego_led_main.sv
// Bench for juego_led_main: stimulus queues each expected output change, a monitor checks every change and hold time.
module tb_juego_led_main;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       BotonA = 1'b0;
  logic       BotonB = 1'b0;
  logic       LedRED, LedVerde, LedFin;
  logic [6:0] displaytotal;
  logic       Switch0, Switch1, Switch2, Switch3;

  juego_led_main dut (
    .clock(clock), .Reset(Reset), .Start(Start), .BotonA(BotonA), .BotonB(BotonB),
    .LedRED(LedRED), .LedVerde(LedVerde), .LedFin(LedFin), .displaytotal(displaytotal),
    .Switch0(Switch0), .Switch1(Switch1), .Switch2(Switch2), .Switch3(Switch3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [13:0] vec;
    int          hold;
    int          tag;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int sa = 0, sb = 0, rnd = 0, tag = 0;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b0111111;
      1: s = 7'b0000110;
      2: s = 7'b1011011;
      3: s = 7'b1001111;
      4: s = 7'b1100110;
      5: s = 7'b1101101;
      6: s = 7'b1111101;
      7: s = 7'b0000111;
      8: s = 7'b1111111;
      9: s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  // Vector layout: {LedRED, LedVerde, LedFin, Switch3, Switch2, Switch1, Switch0, displaytotal}
  function automatic logic [13:0] mk(input logic r, input logic v, input logic f);
    logic [1:0] a2, b2;
    a2 = sa[1:0];
    b2 = sb[1:0];
    return {r, v, f, b2, a2, seg_of(rnd)};
  endfunction

  task automatic push(input logic r, input logic v, input logic f, input int hold);
    exp_t e;
    e.vec  = mk(r, v, f);
    e.hold = hold;
    e.tag  = tag;
    q.push_back(e);
    tag++;
  endtask

  initial begin : monitor
    logic [13:0] prev, cur;
    int cnt, exp_hold, hold_tag;
    exp_t e;
    prev     = 'x;
    cnt      = 0;
    exp_hold = 0;
    hold_tag = 0;
    forever begin
      @(negedge clock);
      cur = {LedRED, LedVerde, LedFin, Switch3, Switch2, Switch1, Switch0, displaytotal};
      if (cur !== prev) begin
        if (exp_hold != 0) begin
          tests++;
          if (cnt != exp_hold) begin
            fails++;
            $display("FAIL hold[%0d]: held %0d cycles, required %0d", hold_tag, cnt, exp_hold);
          end
        end
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_change: got %b, nothing expected", cur);
          exp_hold = 0;
        end else begin
          e = q.pop_front();
          tests++;
          if (cur !== e.vec) begin
            fails++;
            $display("FAIL change[%0d]: got %b, required %b", e.tag, cur, e.vec);
          end
          exp_hold = e.hold;
          hold_tag = e.tag;
        end
        prev = cur;
        cnt  = 1;
      end else begin
        cnt++;
      end
    end
  end

  task automatic press_start();
    Start = 1'b1;
    repeat (3) @(negedge clock);
    Start = 1'b0;
  endtask

  task automatic wait_verde();
    int n = 0;
    while (LedVerde !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (LedVerde !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_verde: LedVerde=%b after %0d cycles, required 1", LedVerde, n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (LedRED !== 1'b1 && LedVerde !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while ((LedRED !== 1'b0 || LedVerde !== 1'b0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (LedRED !== 1'b0 || LedVerde !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: LedRED=%b LedVerde=%b, required 0 0", LedRED, LedVerde);
    end
    repeat (2) @(negedge clock);
  endtask

  // One round with buttons raised during GO; a and b together is a tie
  task automatic go_round(input logic a, input logic b);
    push(1'b0, 1'b1, 1'b0, 0);
    press_start();
    wait_verde();
    if (a && !b && sa < 3) sa++;
    if (b && !a && sb < 3) sb++;
    rnd = (rnd + 1) % 10;
    push(a & b, 1'b1, 1'b0, 4);
    push(1'b0, 1'b0, (sa == 3 || sb == 3), 0);
    BotonA = a;
    BotonB = b;
    repeat (3) @(negedge clock);
    BotonA = 1'b0;
    BotonB = 1'b0;
    wait_idle();
  endtask

  initial begin : stimulus
    push(1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clock);
    Reset = 1'b1;
    repeat (2) @(negedge clock);

    // Void round: no press within the GO window
    push(1'b0, 1'b1, 1'b0, 32);
    rnd = 1;
    push(1'b1, 1'b1, 1'b0, 4);
    push(1'b0, 1'b0, 1'b0, 0);
    press_start();
    wait_verde();
    wait_idle();

    go_round(1'b1, 1'b0);

    // Early A press while waiting: foul, point to B
    sb++;
    rnd++;
    push(1'b1, 1'b0, 1'b0, 4);
    push(1'b0, 1'b0, 1'b0, 0);
    Start = 1'b1;
    @(negedge clock);
    BotonA = 1'b1;
    repeat (3) @(negedge clock);
    Start  = 1'b0;
    BotonA = 1'b0;
    wait_idle();

    go_round(1'b1, 1'b1);
    go_round(1'b1, 1'b0);
    go_round(1'b1, 1'b0);

    // Game over: A/B presses change nothing, Start clears the game
    repeat (2) begin
      BotonA = 1'b1;
      repeat (3) @(negedge clock);
      BotonA = 1'b0;
      repeat (3) @(negedge clock);
    end
    BotonB = 1'b1;
    repeat (3) @(negedge clock);
    BotonB = 1'b0;
    repeat (6) @(negedge clock);
    sa = 0;
    sb = 0;
    rnd = 0;
    push(1'b0, 1'b0, 1'b0, 0);
    press_start();
    repeat (6) @(negedge clock);

    // Reset in the middle of GO with A at 2 points
    go_round(1'b1, 1'b0);
    go_round(1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0, 0);
    press_start();
    wait_verde();
    repeat (3) @(negedge clock);
    sa = 0;
    sb = 0;
    rnd = 0;
    push(1'b0, 1'b0, 1'b0, 0);
    Reset = 1'b0;
    @(negedge clock);
    Reset = 1'b1;
    repeat (3) @(negedge clock);

    go_round(1'b0, 1'b1);

    repeat (5) @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending: %0d expected changes never seen, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
